// File: rtl/ocram_burst_adapter_if.sv
// Bus bundle between an Avalon-MM bursting master and the on-chip RAM it reaches
// through ocram_burst_adapter: master-facing s_* signals and RAM-facing m_* pins.
interface ocram_burst_adapter_if #(
   parameter int ADDR_WIDTH  = 10,
   parameter int DATA_WIDTH  = 32,
   parameter int BURST_WIDTH = 4
);
   logic [ADDR_WIDTH-1:0]   s_address;
   logic [BURST_WIDTH-1:0]  s_burstcount;
   logic                    s_read;
   logic                    s_write;
   logic [DATA_WIDTH-1:0]   s_writedata;
   logic [DATA_WIDTH/8-1:0] s_byteenable;
   logic                    s_waitrequest;
   logic [DATA_WIDTH-1:0]   s_readdata;
   logic                    s_readdatavalid;
   logic [ADDR_WIDTH-1:0]   m_address;
   logic [DATA_WIDTH/8-1:0] m_byteenable;
   logic                    m_chipselect;
   logic                    m_write;
   logic [DATA_WIDTH-1:0]   m_writedata;
   logic                    m_clken;
   logic [DATA_WIDTH-1:0]   m_readdata;

   modport slave (
      input  s_address, s_burstcount, s_read, s_write, s_writedata, s_byteenable, m_readdata,
      output s_waitrequest, s_readdata, s_readdatavalid,
             m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken
   );

   modport master (
      output s_address, s_burstcount, s_read, s_write, s_writedata, s_byteenable, m_readdata,
      input  s_waitrequest, s_readdata, s_readdatavalid,
             m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken
   );
endinterface

// File: rtl/ocram_burst_adapter.sv
// Avalon-MM bursting slave in front of a single-port RAM with a registered address
// port: one RAM access per cycle, readdatavalid rebuilt from the issued reads.
module ocram_burst_adapter #(
   parameter int ADDR_WIDTH  = 10,
   parameter int DATA_WIDTH  = 32,
   parameter int BURST_WIDTH = 4
) (
   input logic                 clk,
   input logic                 reset,
   ocram_burst_adapter_if.slave io_bus
);
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_BURST = 2'd1,
      WR_BURST = 2'd2
   } state_t;

   localparam logic [BURST_WIDTH-1:0]  ONE_BEAT  = {{(BURST_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [BURST_WIDTH-1:0]  ZERO_BEAT = {BURST_WIDTH{1'b0}};
   localparam logic [ADDR_WIDTH-1:0]   ONE_ADDR  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0]   ZERO_ADDR = {ADDR_WIDTH{1'b0}};
   localparam logic [DATA_WIDTH-1:0]   ZERO_DATA = {DATA_WIDTH{1'b0}};
   localparam logic [DATA_WIDTH/8-1:0] ALL_BE    = {(DATA_WIDTH/8){1'b1}};
   localparam logic [DATA_WIDTH/8-1:0] ZERO_BE   = {(DATA_WIDTH/8){1'b0}};

   state_t                  r_state;
   logic [ADDR_WIDTH-1:0]   r_ptr;
   logic [BURST_WIDTH-1:0]  r_remaining;
   logic [ADDR_WIDTH-1:0]   r_m_address;
   logic [DATA_WIDTH-1:0]   r_m_writedata;
   logic [DATA_WIDTH/8-1:0] r_m_byteenable;
   logic                    r_m_chipselect;
   logic                    r_m_write;
   logic                    r_rdvalid;
   logic [BURST_WIDTH-1:0]  w_first_count;

   // A zero burstcount is a single-beat burst.
   always_comb begin
      w_first_count = io_bus.s_burstcount;
      if (io_bus.s_burstcount == ZERO_BEAT) begin
         w_first_count = ONE_BEAT;
      end else begin
         w_first_count = io_bus.s_burstcount;
      end
   end

   // Burst sequencer: the first beat of every command is issued on its accept edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= IDLE;
         r_ptr          <= ZERO_ADDR;
         r_remaining    <= ZERO_BEAT;
         r_m_address    <= ZERO_ADDR;
         r_m_writedata  <= ZERO_DATA;
         r_m_byteenable <= ZERO_BE;
         r_m_chipselect <= 1'b0;
         r_m_write      <= 1'b0;
         r_rdvalid      <= 1'b0;
      end else begin
         r_m_chipselect <= 1'b0;
         r_m_write      <= 1'b0;
         r_rdvalid      <= r_m_chipselect & ~r_m_write;
         case (r_state)
            IDLE: begin
               if (io_bus.s_write) begin
                  r_m_address    <= io_bus.s_address;
                  r_m_writedata  <= io_bus.s_writedata;
                  r_m_byteenable <= io_bus.s_byteenable;
                  r_m_chipselect <= 1'b1;
                  r_m_write      <= 1'b1;
                  r_ptr          <= io_bus.s_address + ONE_ADDR;
                  r_remaining    <= w_first_count - ONE_BEAT;
                  r_state        <= (w_first_count == ONE_BEAT) ? IDLE : WR_BURST;
               end else if (io_bus.s_read) begin
                  r_m_address    <= io_bus.s_address;
                  r_m_byteenable <= ALL_BE;
                  r_m_chipselect <= 1'b1;
                  r_ptr          <= io_bus.s_address + ONE_ADDR;
                  r_remaining    <= w_first_count - ONE_BEAT;
                  r_state        <= RD_BURST;
               end else begin
                  r_state <= IDLE;
               end
            end
            RD_BURST: begin
               // Stay one extra cycle after the last issue so waitrequest spans the burst.
               if (r_remaining != ZERO_BEAT) begin
                  r_m_address    <= r_ptr;
                  r_m_byteenable <= ALL_BE;
                  r_m_chipselect <= 1'b1;
                  r_ptr          <= r_ptr + ONE_ADDR;
                  r_remaining    <= r_remaining - ONE_BEAT;
               end else begin
                  r_state <= IDLE;
               end
            end
            WR_BURST: begin
               if (io_bus.s_write) begin
                  r_m_address    <= r_ptr;
                  r_m_writedata  <= io_bus.s_writedata;
                  r_m_byteenable <= io_bus.s_byteenable;
                  r_m_chipselect <= 1'b1;
                  r_m_write      <= 1'b1;
                  r_ptr          <= r_ptr + ONE_ADDR;
                  r_remaining    <= r_remaining - ONE_BEAT;
                  r_state        <= (r_remaining == ONE_BEAT) ? IDLE : WR_BURST;
               end else begin
                  r_state <= WR_BURST;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign io_bus.s_waitrequest   = reset | (r_state == RD_BURST);
   assign io_bus.s_readdata      = io_bus.m_readdata;
   assign io_bus.s_readdatavalid = r_rdvalid;
   assign io_bus.m_address       = r_m_address;
   assign io_bus.m_byteenable    = r_m_byteenable;
   assign io_bus.m_chipselect    = r_m_chipselect;
   assign io_bus.m_write         = r_m_write;
   assign io_bus.m_writedata     = r_m_writedata;
   assign io_bus.m_clken         = 1'b1;
endmodule

// File: tb/tb_ocram_burst_adapter.sv
// Bench for ocram_burst_adapter: a behavioural registered-address RAM on the m_* side,
// a reference memory image and a queue of expected read beats.
module tb_ocram_burst_adapter;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   logic [31:0] ram     [1024];
   logic [31:0] exp_mem [1024];
   logic [31:0] ram_q;
   logic [31:0] exp_q   [$];

   ocram_burst_adapter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .BURST_WIDTH(4)) bus ();

   ocram_burst_adapter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .BURST_WIDTH(4)) dut (
      .clk    (clk),
      .reset  (reset),
      .io_bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM with registered address: data appears one cycle after the address.
   always @(posedge clk) begin
      if (bus.m_chipselect && bus.m_clken) begin
         if (bus.m_write) begin
            for (int b = 0; b < 4; b++)
               if (bus.m_byteenable[b]) ram[bus.m_address][8*b +: 8] <= bus.m_writedata[8*b +: 8];
         end else begin
            ram_q <= ram[bus.m_address];
         end
      end
   end
   assign bus.m_readdata = ram_q;

   task automatic do_write(input string nm, input logic [9:0] addr, input int n, input logic [3:0] bc,
                           input logic [31:0] d0, input logic [3:0] be, input logic also_read,
                           input int gap_at, input int gap_len);
      int beat = 0; int cyc = 0; int gaps = 0; logic prev_beat = 1'b0;
      logic [9:0] exp_a = 10'd0; logic [9:0] a; logic [31:0] d;
      while (beat < n || prev_beat) begin
         @(negedge clk);
         if (prev_beat) begin
            checks++;
            if (bus.m_chipselect !== 1'b1 || bus.m_write !== 1'b1 || bus.m_address !== exp_a) begin
               errors++;
               $display("FAIL %s beat cs=%b wr=%b addr=%h expected cs=1 wr=1 addr=%h",
                        nm, bus.m_chipselect, bus.m_write, bus.m_address, exp_a);
            end
         end else if (cyc > 0) begin
            checks++;
            if (bus.m_chipselect !== 1'b0) begin
               errors++;
               $display("FAIL %s idle_beat cs=%b expected 0", nm, bus.m_chipselect);
            end
         end
         if (beat < n && !(beat == gap_at && gaps < gap_len)) begin
            a = addr + 10'(beat);
            d = d0 + 32'(beat);
            bus.s_address    = addr;
            bus.s_burstcount = bc;
            bus.s_writedata  = d;
            bus.s_byteenable = be;
            bus.s_write      = 1'b1;
            bus.s_read       = (beat == 0) ? also_read : 1'b0;
            for (int b = 0; b < 4; b++)
               if (be[b]) exp_mem[a][8*b +: 8] = d[8*b +: 8];
            exp_a = a;
            beat++;
            prev_beat = 1'b1;
         end else begin
            if (beat < n) gaps++;
            bus.s_write = 1'b0;
            bus.s_read  = 1'b0;
            prev_beat   = 1'b0;
         end
         cyc++;
      end
   endtask

   task automatic run_reads(input string nm, input logic [9:0] a0, input logic [3:0] bc0,
                            input logic [9:0] a1, input logic [3:0] bc1, input int n_cmds);
      int issued = 0; int total = 0; int got = 0; int cyc = 0; int n;
      int issue_cyc = -1; int first = -1; int last = -1; int wr_hi = 0;
      logic [31:0] exp_d; logic [9:0] a; logic [9:0] ai; logic [3:0] bc;
      while (!(issued == n_cmds && got == total && bus.s_read == 1'b0) && cyc < 80) begin
         @(negedge clk);
         cyc++;
         if (bus.s_waitrequest) wr_hi++;
         if (bus.s_readdatavalid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL %s stray_beat data=%h expected no beat", nm, bus.s_readdata);
            end else begin
               exp_d = exp_q.pop_front();
               if (bus.s_readdata !== exp_d) begin
                  errors++;
                  $display("FAIL %s data got=%h expected=%h", nm, bus.s_readdata, exp_d);
               end
            end
            if (first < 0) first = cyc;
            last = cyc;
            got++;
         end
         if (bus.s_read) begin
            bus.s_read = 1'b0;
         end else if (issued < n_cmds && !bus.s_waitrequest) begin
            a  = (issued == 0) ? a0 : a1;
            bc = (issued == 0) ? bc0 : bc1;
            n  = (bc == 4'd0) ? 1 : int'(bc);
            bus.s_address    = a;
            bus.s_burstcount = bc;
            bus.s_write      = 1'b0;
            bus.s_read       = 1'b1;
            for (int i = 0; i < n; i++) begin
               ai = a + 10'(i);
               exp_q.push_back(exp_mem[ai]);
            end
            if (issued == 0) issue_cyc = cyc;
            total += n;
            issued++;
         end
      end
      bus.s_read = 1'b0;
      checks++;
      if (cyc >= 80) begin
         errors++;
         $display("FAIL %s timeout beats=%0d expected=%0d", nm, got, total);
      end
      checks++;
      if (first - issue_cyc != 2) begin
         errors++;
         $display("FAIL %s latency got=%0d expected=2", nm, first - issue_cyc);
      end
      checks++;
      if (last - first + 1 != total + n_cmds - 1) begin
         errors++;
         $display("FAIL %s span got=%0d expected=%0d", nm, last - first + 1, total + n_cmds - 1);
      end
      checks++;
      if (wr_hi != total) begin
         errors++;
         $display("FAIL %s waitreq_cycles got=%0d expected=%0d", nm, wr_hi, total);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.s_waitrequest !== 1'b1 || bus.s_readdatavalid !== 1'b0 || bus.m_clken !== 1'b1) begin
         errors++;
         $display("FAIL reset_flags wait=%b valid=%b clken=%b expected 1 0 1",
                  bus.s_waitrequest, bus.s_readdatavalid, bus.m_clken);
      end
      checks++;
      if (bus.m_chipselect !== 1'b0 || bus.m_write !== 1'b0 || bus.m_address !== 10'd0 ||
          bus.m_byteenable !== 4'd0 || bus.m_writedata !== 32'd0) begin
         errors++;
         $display("FAIL reset_m cs=%b wr=%b addr=%h be=%h wd=%h expected all 0", bus.m_chipselect,
                  bus.m_write, bus.m_address, bus.m_byteenable, bus.m_writedata);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.s_waitrequest !== 1'b0) begin
         errors++;
         $display("FAIL reset_release wait=%b expected 0", bus.s_waitrequest);
      end
   endtask

   task automatic test_single_read();
      run_reads("single_read", 10'h005, 4'd1, 10'h000, 4'd0, 1);
      checks++;
      if (exp_mem[5] !== 32'h14 || ram[5] !== 32'h14) begin
         errors++;
         $display("FAIL single_read_image got=%h expected=00000014", ram[5]);
      end
   endtask

   task automatic test_wrap_burst();
      do_write("wrap_write", 10'h3FC, 8, 4'd8, 32'hA0, 4'hF, 1'b0, -1, 0);
      @(negedge clk);
      checks++;
      if (ram[10'h000] !== 32'hA4 || ram[10'h003] !== 32'hA7 || ram[10'h3FF] !== 32'hA3) begin
         errors++;
         $display("FAIL wrap_land got=%h %h %h expected=000000a3 000000a4 000000a7",
                  ram[10'h3FF], ram[10'h000], ram[10'h003]);
      end
      run_reads("wrap_read", 10'h3FC, 4'd8, 10'h000, 4'd0, 1);
   endtask

   task automatic test_byteenable();
      do_write("be_base", 10'h010, 1, 4'd1, 32'h11223344, 4'hF, 1'b0, -1, 0);
      do_write("be_merge", 10'h010, 1, 4'd1, 32'hDEADBEEF, 4'b0101, 1'b0, -1, 0);
      @(negedge clk);
      checks++;
      if (ram[10'h010] !== 32'h11AD33EF) begin
         errors++;
         $display("FAIL be_merge got=%h expected=11ad33ef", ram[10'h010]);
      end
      run_reads("be_read", 10'h010, 4'd1, 10'h000, 4'd0, 1);
   endtask

   task automatic test_read_write_collision();
      do_write("rw_both", 10'h020, 1, 4'd0, 32'h55AA1234, 4'hF, 1'b1, -1, 0);
      checks++;
      if (bus.s_waitrequest !== 1'b0) begin
         errors++;
         $display("FAIL rw_idle wait=%b expected 0", bus.s_waitrequest);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (bus.s_readdatavalid !== 1'b0 || bus.m_chipselect !== 1'b0) begin
            errors++;
            $display("FAIL rw_no_read valid=%b cs=%b expected 0 0", bus.s_readdatavalid, bus.m_chipselect);
         end
      end
      checks++;
      if (ram[10'h020] !== 32'h55AA1234) begin
         errors++;
         $display("FAIL rw_written got=%h expected=55aa1234", ram[10'h020]);
      end
   endtask

   task automatic test_reset_mid_burst();
      @(negedge clk);
      bus.s_address    = 10'h040;
      bus.s_burstcount = 4'd6;
      bus.s_read       = 1'b1;
      @(negedge clk);
      bus.s_read = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (bus.s_readdatavalid !== 1'b0 || bus.m_chipselect !== 1'b0 || bus.s_waitrequest !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset valid=%b cs=%b wait=%b expected 0 0 1",
                  bus.s_readdatavalid, bus.m_chipselect, bus.s_waitrequest);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (bus.s_readdatavalid !== 1'b0 || bus.m_chipselect !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_stale valid=%b cs=%b expected 0 0", bus.s_readdatavalid, bus.m_chipselect);
         end
      end
      run_reads("after_reset", 10'h045, 4'd1, 10'h000, 4'd0, 1);
   endtask

   task automatic test_write_gap();
      do_write("gap_write", 10'h100, 4, 4'd4, 32'hC0, 4'hF, 1'b0, 2, 2);
      @(negedge clk);
      run_reads("gap_read", 10'h100, 4'd4, 10'h000, 4'd0, 1);
   endtask

   task automatic test_back_to_back();
      run_reads("back_to_back", 10'h080, 4'd4, 10'h3FE, 4'd3, 2);
   endtask

   initial begin
      reset            = 1'b1;
      checks           = 0;
      errors           = 0;
      ram_q            = 32'd0;
      bus.s_address    = 10'd0;
      bus.s_burstcount = 4'd0;
      bus.s_read       = 1'b0;
      bus.s_write      = 1'b0;
      bus.s_writedata  = 32'd0;
      bus.s_byteenable = 4'hF;
      for (int i = 0; i < 1024; i++) begin
         ram[i]     = 32'(i * 4);
         exp_mem[i] = 32'(i * 4);
      end
      test_reset();
      test_single_read();
      test_wrap_burst();
      test_byteenable();
      test_read_write_collision();
      test_reset_mid_burst();
      test_write_gap();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end
endmodule
